// File: rtl/ps_pkg.sv
// Shared types and defaults for the parallel-to-serial transmitter.
// Holds the FSM state encoding, the idle comma and the init-length default.
package ps_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] COMMA_DEFAULT       = 8'hBC;
  localparam int         INIT_COMMAS_DEFAULT = 4;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps_word_shifter.sv
// Word-slot shifter: bit counter, shift register and bit ordering.
// Produces the load strobe and the registered serial/word_start/data_active outputs.
module ps_word_shifter
  import ps_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk8f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] load_word,
  input  logic              load_is_data,
  output logic              load,
  output logic              serial,
  output logic              word_start,
  output logic              data_active
);

  localparam int                CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              started_q, started_d;
  logic              serial_q, serial_d;
  logic              word_start_q, word_start_d;
  logic              data_active_q, data_active_d;

  // started_q forces a word boundary on the very first edge after reset release.
  assign load = !started_q || (bit_cnt_q == LAST_BIT);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    started_d     = started_q;
    serial_d      = serial_q;
    word_start_d  = 1'b0;
    data_active_d = data_active_q;
    if (load) begin
      bit_cnt_d     = '0;
      started_d     = 1'b1;
      word_start_d  = 1'b1;
      data_active_d = load_is_data;
      if (LSB_FIRST) begin
        serial_d = load_word[0];
        shreg_d  = load_word >> 1;
      end else begin
        serial_d = load_word[DATA_W-1];
        shreg_d  = load_word << 1;
      end
    end else begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (LSB_FIRST) begin
        serial_d = shreg_q[0];
        shreg_d  = shreg_q >> 1;
      end else begin
        serial_d = shreg_q[DATA_W-1];
        shreg_d  = shreg_q << 1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      started_q     <= 1'b0;
      serial_q      <= 1'b0;
      word_start_q  <= 1'b0;
      data_active_q <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      started_q     <= started_d;
      serial_q      <= serial_d;
      word_start_q  <= word_start_d;
      data_active_q <= data_active_d;
    end
  end

  assign serial      = serial_q;
  assign word_start  = word_start_q;
  assign data_active = data_active_q;

endmodule

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial transmitter top: init/run FSM, comma counter and one-entry
// holding register feeding the word shifter; commas fill every idle slot.
module paralelo_serial_param
  import ps_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] COMMA       = DATA_W'(COMMA_DEFAULT),
  parameter int                INIT_COMMAS = INIT_COMMAS_DEFAULT,
  parameter bit                LSB_FIRST   = 1'b0
) (
  input  logic              clk8f,
  input  logic              reset_L,
  input  logic              init,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial,
  output logic              word_start,
  output logic              data_active
);

  localparam int                 ICNT_W   = cnt_width(INIT_COMMAS + 1);
  localparam logic [ICNT_W-1:0] ICNT_TGT = ICNT_W'(INIT_COMMAS);

  state_e            state_q, state_d;
  logic [ICNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;

  logic              load;
  logic              load_data;
  logic              accept;
  logic              init_done;
  logic [DATA_W-1:0] shift_word;

  // A load carries data only if it also leaves (or stays out of) INIT on this edge.
  always_comb begin
    init_done  = (init_cnt_q >= ICNT_TGT);
    load_data  = load && hold_full_q && !init && ((state_q == ST_RUN) || init_done);
    in_ready   = reset_L && (!hold_full_q || load_data);
    accept     = in_valid && in_ready;
    shift_word = load_data ? hold_q : COMMA;
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (init) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
    end else if (load && (state_q == ST_INIT)) begin
      if (init_done) state_d = ST_RUN;
      else           init_cnt_d = init_cnt_q + ICNT_W'(1);
    end

    // A simultaneous accept and consume leaves the register full with the new word.
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end else if (load_data) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      // NOTE: the word register is reset too; it is a single entry, not a RAM, so the cost is trivial.
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  ps_word_shifter #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_shifter (
    .clk8f        (clk8f),
    .reset_L      (reset_L),
    .load_word    (shift_word),
    .load_is_data (load_data),
    .load         (load),
    .serial       (serial),
    .word_start   (word_start),
    .data_active  (data_active)
  );

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Directed bench for paralelo_serial_param: default MSB-first 8-bit instance plus
// an LSB-first 10-bit instance; expected slot contents are hand-computed constants.
module tb_paralelo_serial_param;

  logic       clk8f = 1'b0;
  logic       reset_L;

  logic       a_init, a_valid, a_ready, a_serial, a_ws, a_da;
  logic [7:0] a_data;

  logic       b_init, b_valid, b_ready, b_serial, b_ws, b_da;
  logic [9:0] b_data;

  int vectors    = 0;
  int miscompares = 0;
  int rdy;

  localparam logic [15:0] A_COMMA = 16'h00BC;
  localparam logic [15:0] B_COMMA = 16'h00FA;  // 10'h17C sent LSB first
  localparam logic [15:0] B_WORD  = 16'h0295;  // 10'h2A5 sent LSB first

  always #5 clk8f = ~clk8f;

  paralelo_serial_param dut_a (
    .clk8f       (clk8f),
    .reset_L     (reset_L),
    .init        (a_init),
    .in_data     (a_data),
    .in_valid    (a_valid),
    .in_ready    (a_ready),
    .serial      (a_serial),
    .word_start  (a_ws),
    .data_active (a_da)
  );

  paralelo_serial_param #(
    .DATA_W      (10),
    .COMMA       (10'h17C),
    .INIT_COMMAS (4),
    .LSB_FIRST   (1'b1)
  ) dut_b (
    .clk8f       (clk8f),
    .reset_L     (reset_L),
    .init        (b_init),
    .in_data     (b_data),
    .in_valid    (b_valid),
    .in_ready    (b_ready),
    .serial      (b_serial),
    .word_start  (b_ws),
    .data_active (b_da)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Capture one word slot, one sample per falling edge, first bit ends up as MSB.
  task automatic grab(input bit sel_b, input int w, output logic [15:0] bits,
                      output logic [15:0] ws, output logic [15:0] da, output int nrdy);
    bits = '0; ws = '0; da = '0; nrdy = 0;
    for (int i = 0; i < w; i++) begin
      @(negedge clk8f);
      if (sel_b) begin
        bits = {bits[14:0], b_serial};
        ws   = {ws[14:0], b_ws};
        da   = {da[14:0], b_da};
        if (b_ready) nrdy++;
      end else begin
        bits = {bits[14:0], a_serial};
        ws   = {ws[14:0], a_ws};
        da   = {da[14:0], a_da};
        if (a_ready) nrdy++;
      end
    end
  endtask

  task automatic expect_slot(input string tag, input bit sel_b, input int w,
                             input logic [15:0] exp_bits, input bit exp_data, output int nrdy);
    logic [15:0] bits, ws, da, mask;
    grab(sel_b, w, bits, ws, da, nrdy);
    mask = (16'h1 << w) - 16'h1;
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_ws"}, ws, 16'h1 << (w - 1));
    check({tag, "_da"}, da, exp_data ? mask : 16'h0);
  endtask

  // Present a word on A and hold it until one transfer edge has passed.
  task automatic offer(input logic [7:0] w, input string tag);
    a_data  = w;
    a_valid = 1'b1;
    for (int t = 0; t < 32 && !a_ready; t++) @(negedge clk8f);
    check({tag, "_ready_wait"}, a_ready, 1);
    @(posedge clk8f);
    #1 a_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    a_init = 1'b0; a_valid = 1'b0; a_data = '0;
    b_init = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (3) @(negedge clk8f);

    check("rst_a_serial", a_serial, 0);
    check("rst_a_ws", a_ws, 0);
    check("rst_a_da", a_da, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_serial", b_serial, 0);
    check("rst_b_ready", b_ready, 0);

    // Idle after reset: commas, always ready.
    reset_L = 1'b1;
    expect_slot("idle0", 0, 8, A_COMMA, 0, rdy);
    check("idle0_rdy", rdy, 8);
    expect_slot("idle1", 0, 8, A_COMMA, 0, rdy);
    check("idle1_rdy", rdy, 8);

    // Word offered from reset waits for four commas.
    reset_L = 1'b0;
    a_data  = 8'hA5;
    a_valid = 1'b1;
    #1;
    check("rst2_ready", a_ready, 0);
    check("rst2_serial", a_serial, 0);
    repeat (2) @(negedge clk8f);
    reset_L = 1'b1;
    @(posedge clk8f);
    #1 a_valid = 1'b0;
    expect_slot("a5_c1", 0, 8, A_COMMA, 0, rdy);
    check("a5_c1_rdy", rdy, 0);
    expect_slot("a5_c2", 0, 8, A_COMMA, 0, rdy);
    expect_slot("a5_c3", 0, 8, A_COMMA, 0, rdy);
    expect_slot("a5_c4", 0, 8, A_COMMA, 0, rdy);
    expect_slot("a5_data", 0, 8, 16'h00A5, 1, rdy);
    check("a5_data_rdy", rdy, 8);
    expect_slot("a5_after", 0, 8, A_COMMA, 0, rdy);

    // Back-to-back words with valid kept up.
    fork
      begin
        offer(8'h01, "w1");
        offer(8'h02, "w2");
        offer(8'h03, "w3");
      end
      begin
        expect_slot("b2b_lead", 0, 8, A_COMMA, 0, rdy);
        check("b2b_lead_rdy", rdy, 1);
        expect_slot("b2b_w1", 0, 8, 16'h0001, 1, rdy);
        check("b2b_w1_rdy", rdy, 1);
        expect_slot("b2b_w2", 0, 8, 16'h0002, 1, rdy);
        check("b2b_w2_rdy", rdy, 1);
      end
    join
    expect_slot("b2b_w3", 0, 8, 16'h0003, 1, rdy);
    check("b2b_w3_rdy", rdy, 8);
    expect_slot("b2b_tail", 0, 8, A_COMMA, 0, rdy);

    // init pulse in the middle of a data word; second word held across INIT.
    fork
      begin
        offer(8'h3C, "i1");
        offer(8'h5A, "i2");
      end
      expect_slot("init_lead", 0, 8, A_COMMA, 0, rdy);
    join
    fork
      begin
        repeat (3) @(posedge clk8f);
        #1 a_init = 1'b1;
        @(posedge clk8f);
        #1 a_init = 1'b0;
      end
      expect_slot("init_cur", 0, 8, 16'h003C, 1, rdy);
    join
    expect_slot("init_c1", 0, 8, A_COMMA, 0, rdy);
    check("init_c1_rdy", rdy, 0);
    expect_slot("init_c2", 0, 8, A_COMMA, 0, rdy);
    expect_slot("init_c3", 0, 8, A_COMMA, 0, rdy);
    expect_slot("init_c4", 0, 8, A_COMMA, 0, rdy);
    expect_slot("init_held", 0, 8, 16'h005A, 1, rdy);
    check("init_held_rdy", rdy, 8);

    // Reset during bit 3 of a data word with another word held.
    fork
      begin
        offer(8'hF0, "r1");
        offer(8'h77, "r2");
      end
      expect_slot("rmid_lead", 0, 8, A_COMMA, 0, rdy);
    join
    repeat (3) @(posedge clk8f);
    #1;
    check("rmid_pre_serial", a_serial, 1);
    check("rmid_pre_da", a_da, 1);
    reset_L = 1'b0;
    #1;
    check("rmid_serial", a_serial, 0);
    check("rmid_ws", a_ws, 0);
    check("rmid_da", a_da, 0);
    check("rmid_ready", a_ready, 0);
    repeat (2) @(negedge clk8f);
    reset_L = 1'b1;
    for (int s = 0; s < 5; s++) begin
      expect_slot($sformatf("rpost%0d", s), 0, 8, A_COMMA, 0, rdy);
    end

    // LSB-first, 10-bit instance.
    reset_L = 1'b0;
    b_data  = 10'h2A5;
    b_valid = 1'b1;
    repeat (2) @(negedge clk8f);
    reset_L = 1'b1;
    @(posedge clk8f);
    #1 b_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      expect_slot($sformatf("lsb_c%0d", s), 1, 10, B_COMMA, 0, rdy);
    end
    expect_slot("lsb_data", 1, 10, B_WORD, 1, rdy);
    expect_slot("lsb_after", 1, 10, B_COMMA, 0, rdy);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
